// File: rtl/ball_motion_if.sv
// Ball engine bundle: serve request and paddle rows in, ball coordinates and
// game events out.
interface ball_motion_if;
  logic       start;
  logic [2:0] paddle_l;
  logic [2:0] paddle_r;
  logic [2:0] X;
  logic [2:0] Y;
  logic       running;
  logic       hit;
  logic       miss_l;
  logic       miss_r;

  modport master (
    output start, paddle_l, paddle_r,
    input  X, Y, running, hit, miss_l, miss_r
  );

  modport slave (
    input  start, paddle_l, paddle_r,
    output X, Y, running, hit, miss_l, miss_r
  );
endinterface

// File: rtl/ball_motion.sv
// Ball motion engine for the 8x8 ping-pong field: steps the ball once per game
// tick, bounces it off walls and paddles, and reports hits and misses.
module ball_motion #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int PADDLE_LEN = 3
) (
  input logic         clk,
  input logic         rst,
  ball_motion_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int         CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] PMAX  = 4'(8 - PADDLE_LEN);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             over_cnt;
  logic [2:0]       x, y;
  logic             dx, dy, serve_dx;
  logic             running, hit, miss_l, miss_r;

  logic [2:0] nx, ny;
  logic       ndx, ndy, hit_c, miss_l_c, miss_r_c;
  logic       tick;

  function automatic logic [3:0] clamp_pad(input logic [2:0] p);
    logic [3:0] p4;
    p4 = {1'b0, p};
    return (p4 > PMAX) ? PMAX : p4;
  endfunction

  // Coverage is evaluated in 4 bits so top+PADDLE_LEN-1 never wraps past row 7.
  function automatic logic covers(input logic [3:0] top, input logic [2:0] row);
    logic [3:0] r4;
    r4 = {1'b0, row};
    return (r4 >= top) && (r4 <= top + 4'(PADDLE_LEN - 1));
  endfunction

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_comb begin
    ny       = y;
    ndy      = dy;
    nx       = x;
    ndx      = dx;
    hit_c    = 1'b0;
    miss_l_c = 1'b0;
    miss_r_c = 1'b0;

    if (dy) begin
      if (y == 3'd7) begin
        ny  = 3'd6;
        ndy = 1'b0;
      end else begin
        ny = y + 3'd1;
      end
    end else begin
      if (y == 3'd0) begin
        ny  = 3'd1;
        ndy = 1'b1;
      end else begin
        ny = y - 3'd1;
      end
    end

    // Paddle test uses the row the ball occupies before this move.
    if (dx) begin
      if (x == 3'd6) begin
        if (covers(clamp_pad(bus.paddle_r), y)) begin
          nx    = 3'd5;
          ndx   = 1'b0;
          hit_c = 1'b1;
        end else begin
          nx       = 3'd7;
          miss_r_c = 1'b1;
        end
      end else begin
        nx = x + 3'd1;
      end
    end else begin
      if (x == 3'd1) begin
        if (covers(clamp_pad(bus.paddle_l), y)) begin
          nx    = 3'd2;
          ndx   = 1'b1;
          hit_c = 1'b1;
        end else begin
          nx       = 3'd0;
          miss_l_c = 1'b1;
        end
      end else begin
        nx = x - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      over_cnt <= 1'b0;
      x        <= 3'd3;
      y        <= 3'd3;
      dx       <= 1'b1;
      dy       <= 1'b1;
      serve_dx <= 1'b1;
      running  <= 1'b0;
      hit      <= 1'b0;
      miss_l   <= 1'b0;
      miss_r   <= 1'b0;
    end else begin
      hit    <= 1'b0;
      miss_l <= 1'b0;
      miss_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          x   <= 3'd3;
          y   <= 3'd3;
          cnt <= '0;
          if (bus.start) begin
            dx      <= serve_dx;
            dy      <= 1'b1;
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) begin
            cnt    <= '0;
            x      <= nx;
            y      <= ny;
            dx     <= ndx;
            dy     <= ndy;
            hit    <= hit_c;
            miss_l <= miss_l_c;
            miss_r <= miss_r_c;
            if (miss_l_c || miss_r_c) begin
              serve_dx <= miss_r_c;
              state    <= ST_OVER;
              running  <= 1'b0;
              over_cnt <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_OVER: begin
          if (tick) begin
            cnt <= '0;
            if (over_cnt) begin
              state <= ST_IDLE;
              x     <= 3'd3;
              y     <= 3'd3;
            end else begin
              over_cnt <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.X       = x;
  assign bus.Y       = y;
  assign bus.running = running;
  assign bus.hit     = hit;
  assign bus.miss_l  = miss_l;
  assign bus.miss_r  = miss_r;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: a cycle model feeds a scoreboard of expected outputs,
// plus directed checks of the serve, bounce, miss, clamp and reset scenarios.
module tb_ball_motion;

  localparam int TD = 4;
  localparam int PL = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ball_motion_if bus();

  ball_motion #(.TICK_DIV(TD), .PADDLE_LEN(PL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       run;
    logic       hit;
    logic       ml;
    logic       mr;
  } exp_t;

  exp_t sb[$];

  int m_st = 0, m_x = 3, m_y = 3, m_dx = 1, m_dy = 1, m_sdx = 1, m_cnt = 0, m_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: integer position plus signed step, reflected when it leaves the field.
  task automatic model_step(output exp_t e);
    int  ny, ndy, nx, ndx, top;
    bit  h, ml, mr;
    h = 0; ml = 0; mr = 0;
    if (rst) begin
      m_st = 0; m_x = 3; m_y = 3; m_dx = 1; m_dy = 1; m_sdx = 1; m_cnt = 0; m_ovr = 0;
    end else begin
      case (m_st)
        0: begin
          m_x = 3; m_y = 3; m_cnt = 0;
          if (bus.start) begin m_dx = m_sdx; m_dy = 1; m_st = 1; end
        end
        1: begin
          if (m_cnt == TD - 1) begin
            m_cnt = 0;
            ny = m_y + m_dy; ndy = m_dy;
            if (ny > 7) begin ny = 6; ndy = -1; end
            else if (ny < 0) begin ny = 1; ndy = 1; end
            nx = m_x + m_dx; ndx = m_dx;
            if (nx == 7 || nx == 0) begin
              top = (nx == 7) ? int'(bus.paddle_r) : int'(bus.paddle_l);
              if (top > 8 - PL) top = 8 - PL;
              if (m_y >= top && m_y < top + PL) begin
                h = 1; nx = (nx == 7) ? 5 : 2; ndx = -m_dx;
              end else begin
                if (nx == 7) begin mr = 1; m_sdx = 1; end
                else begin ml = 1; m_sdx = -1; end
                m_st = 2; m_ovr = 0;
              end
            end
            m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          if (m_cnt == TD - 1) begin
            m_cnt = 0;
            if (m_ovr != 0) begin m_st = 0; m_x = 3; m_y = 3; end
            else m_ovr = 1;
          end else begin
            m_cnt++;
          end
        end
      endcase
    end
    e.x = 3'(m_x); e.y = 3'(m_y); e.run = (m_st == 1);
    e.hit = h; e.ml = ml; e.mr = mr;
  endtask

  task automatic step(input int n);
    exp_t e, o;
    for (int i = 0; i < n; i++) begin
      model_step(e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        o = sb.pop_front();
        chk("pos", {26'd0, bus.X, bus.Y}, {26'd0, o.x, o.y});
        chk("flags", {28'd0, bus.running, bus.hit, bus.miss_l, bus.miss_r},
            {28'd0, o.run, o.hit, o.ml, o.mr});
      end
    end
  endtask

  function automatic logic [31:0] xy(input int x, input int y);
    return 32'((x << 3) | y);
  endfunction

  task automatic chk_xy(input string tag, input int x, input int y);
    chk(tag, {26'd0, bus.X, bus.Y}, xy(x, y));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.paddle_l = 3'd0;
    bus.paddle_r = 3'd0;
    step(2);
    rst = 1'b0;
    chk_xy("reset_pos", 3, 3);
    chk("reset_run", {31'd0, bus.running}, 32'd0);

    // right miss, OVER hold, then serve rightward again
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    chk("start_run", {31'd0, bus.running}, 32'd1);
    step(4); chk_xy("serve1", 4, 4);
    step(4); chk_xy("serve2", 5, 5);
    step(4); chk_xy("serve3", 6, 6);
    bus.paddle_r = 3'd0;
    step(4); chk_xy("miss_r_pos", 7, 7);
    chk("miss_r", {31'd0, bus.miss_r}, 32'd1);
    chk("miss_r_run", {31'd0, bus.running}, 32'd0);
    step(1); chk("miss_r_pulse", {31'd0, bus.miss_r}, 32'd0);
    step(6); chk_xy("over_hold", 7, 7);
    step(1); chk_xy("over_idle", 3, 3);
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    step(4); chk_xy("reserve_r", 4, 4);

    // right paddle hit, wall bounce, left miss
    step(8); chk_xy("to66", 6, 6);
    bus.paddle_r = 3'd5;
    step(4); chk_xy("hit_pos", 5, 7);
    chk("hit", {31'd0, bus.hit}, 32'd1);
    step(1); chk("hit_pulse", {31'd0, bus.hit}, 32'd0);
    step(3); chk_xy("wall", 4, 6);
    step(12); chk_xy("to13", 1, 3);
    bus.paddle_l = 3'd0;
    step(4); chk_xy("miss_l_pos", 0, 2);
    chk("miss_l", {31'd0, bus.miss_l}, 32'd1);
    step(8); chk_xy("idle2", 3, 3);
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    step(4); chk_xy("serve_left", 2, 4);

    // left paddle hit, then reset mid-game at (5,5)
    bus.paddle_l = 3'd4;
    step(4); chk_xy("to15", 1, 5);
    step(4); chk_xy("hit_l", 2, 6);
    chk("hit_l_flag", {31'd0, bus.hit}, 32'd1);
    step(12); chk_xy("to55", 5, 5);
    rst = 1'b1; step(1); rst = 1'b0;
    chk_xy("mid_rst_pos", 3, 3);
    chk("mid_rst_flags", {28'd0, bus.running, bus.hit, bus.miss_l, bus.miss_r}, 32'd0);

    // start pulses in RUN are ignored; paddle_r=7 clamps to 5
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step(1); bus.start = 1'b1; step(1); bus.start = 1'b0; step(2);
      chk_xy("ign_start", 4 + t, 4 + t);
    end
    bus.paddle_r = 3'd7;
    step(4); chk_xy("clamp_pos", 5, 7);
    chk("clamp_hit", {31'd0, bus.hit}, 32'd1);

    // random play against the model
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 5) == 0);
      if ((c % 4) == 0) begin
        bus.paddle_l = 3'($urandom_range(0, 7));
        bus.paddle_r = 3'($urandom_range(0, 7));
      end
      step(1);
    end
    rst = 1'b0;
    bus.start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball motion engine for the 8x8 LED ping-pong field. It owns the ball position and direction, advances the ball one cell per game tick, and bounces the ball off the top and bottom walls and off the paddles. It detects misses and drives the 3-bit X/Y ball coordinates that feed directly into the ball row/column decoder driving the matrix.

## Interface

Parameters:
- TICK_DIV, 25_000_000: clock cycles per ball move. Minimum 2.
- PADDLE_LEN, 3: paddle height in rows. Allowed range 1..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  serve request. Sampled only in IDLE.
- paddle_l  in  3  top row of the left paddle in column 0. Values above 8-PADDLE_LEN are clamped to 8-PADDLE_LEN.
- paddle_r  in  3  top row of the right paddle in column 7. Clamped the same way.
- X  out  3  ball column, 0 = left. Registered.
- Y  out  3  ball row, 0 = top. Registered.
- running  out  1  high while in RUN.
- hit  out  1  one-cycle pulse on a paddle bounce.
- miss_l  out  1  one-cycle pulse when the ball passes the left paddle.
- miss_r  out  1  one-cycle pulse when the ball passes the right paddle.

## Operation

- Direction state:
  - dx: +1 = moving right.
  - dy: +1 = moving down.
  - serve_dx: direction used for the next serve.
- States: IDLE, RUN, OVER.
- IDLE:
  - Ball is held at (3,3).
  - start=1 loads dx=serve_dx and dy=+1, then enters RUN.
- RUN: on each tick, X and Y are updated in the same cycle.
- Y update uses the current Y and dy:
  - dy=+1, Y<7: Y+1.
  - dy=+1, Y=7: Y=6, dy=-1.
  - dy=-1, Y>0: Y-1.
  - dy=-1, Y=0: Y=1, dy=+1.
- X update uses the current X, dx and the current (pre-update) Y:
  - dx=+1, X<6: X+1.
  - dx=+1, X=6, right paddle covers Y: X=5, dx=-1, hit pulses.
  - dx=+1, X=6, right paddle does not cover Y: X=7, miss_r pulses, serve_dx=+1, go to OVER.
  - The left side mirrors this at X=1: X=0, miss_l, serve_dx=-1.
- Paddle coverage:
  - Covers means clamped_p <= Y <= clamped_p+PADDLE_LEN-1.
  - Compare in 4-bit arithmetic so there is no wrap.
- Wall bounce and paddle check on the same tick are independent. Corner hits reflect both dx and dy.
- OVER:
  - Ball is held at the miss cell (X=0 or 7, Y as updated).
  - After 2 ticks go to IDLE with the ball reset to (3,3).
- start outside IDLE is ignored.

## Timing

- Reset values:
  - State IDLE.
  - X=3, Y=3.
  - dx=+1, dy=+1, serve_dx=+1.
  - Tick counter 0.
  - running=0, hit=0, miss_l=0, miss_r=0.
- Reset mid-game returns to the reset values on the next edge. No pulse is emitted.
- Tick counter:
  - Counts 0..TICK_DIV-1 in RUN and OVER.
  - Cleared to 0 in IDLE and on the IDLE->RUN transition.
  - The tick fires when the count equals TICK_DIV-1.
- Latency, start to RUN: start high in IDLE at edge n gives running=1 after edge n.
- Latency, RUN to first move: the first position update happens TICK_DIV cycles after entering RUN.
- hit, miss_l and miss_r go high on the same edge as the X/Y update that causes them. They are high for exactly 1 cycle.
- OVER to IDLE:
  - OVER lasts exactly 2*TICK_DIV cycles.
  - running drops on the edge that enters OVER.
- X/Y change only on tick edges, on the OVER->IDLE edge, and on reset.

## Test plan

All scenarios use TICK_DIV=4 and PADDLE_LEN=3.

1. Serve: reset, then pulse start.
   - running=1 on the next cycle.
   - Positions at 4-cycle intervals: (4,4), (5,5), (6,6).
2. Right hit: continue scenario 1 with paddle_r=5.
   - Next tick: (5,7) and hit pulses once.
   - Next tick: (4,6), from the wall bounce (dy=-1).
3. Right miss: as scenario 1 but with paddle_r=0.
   - Next tick: (7,7), miss_r pulses and running=0.
   - 8 cycles later X/Y=(3,3) and state is IDLE.
   - Next start serves with dx=+1.
4. Left miss and serve direction: drive the ball left with paddle_l=0 and Y in rows 3..7 at X=1.
   - Next tick: X=0 and miss_l pulses.
   - After OVER, start moves the ball to X=2 on the first tick.
5. Clamp and ignore:
   - paddle_r=7 is treated as 5, so a ball at (6,5) hits.
   - start pulses during RUN do not change position or timing.
6. Mid-game reset: assert rst for 1 cycle at (5,5) in RUN.
   - Next cycle: (3,3), IDLE, running=0, no hit/miss pulse.
